// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register, write-data select, halt/error/retire tracking
module writeback_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              reg_wrt_i,
    input  logic [ADDR_W-1:0] write_reg_i,
    input  logic [2:0]        reg_wrt_data_src_i,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic [DATA_W-1:0] next_pc_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              cond_i,
    input  logic              halt_i,
    input  logic              in_err_i,
    output logic [DATA_W-1:0] reg_wrt_data_o,
    output logic              reg_wrt_en_o,
    output logic [ADDR_W-1:0] reg_wrt_addr_o,
    output logic              halted_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);
    typedef struct packed {
        logic              reg_wrt;
        logic [ADDR_W-1:0] waddr;
        logic [2:0]        src;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] mem;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic              cond;
        logic              halt;
        logic              in_err;
    } mw_t;

    mw_t               mw_q, mw_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              legal, retire;
    logic [DATA_W-1:0] sel;

    assign legal  = mw_q.src <= 3'd4;
    assign retire = valid_q & ~stall_i & ~halted_q;
    assign sel    = mw_q.src == 3'd0 ? mw_q.alu :
                    mw_q.src == 3'd1 ? mw_q.mem :
                    mw_q.src == 3'd2 ? mw_q.pc  :
                    mw_q.src == 3'd3 ? mw_q.imm :
                    mw_q.src == 3'd4 ? {{(DATA_W-1){1'b0}}, mw_q.cond} : '0;

    assign reg_wrt_data_o = valid_q ? sel : '0;
    assign reg_wrt_en_o   = valid_q & mw_q.reg_wrt & ~mw_q.halt & ~halted_q & legal;
    assign reg_wrt_addr_o = mw_q.waddr;
    assign halted_o       = halted_q;
    assign err_o          = err_q;
    assign retire_cnt_o   = cnt_q;

    // Next state: flush and a completed HALT both force a bubble; stall holds the held instruction
    always_comb begin
        mw_d     = (stall_i && !flush_i) ? mw_q :
                   mw_t'{reg_wrt_i, write_reg_i, reg_wrt_data_src_i, alu_result_i, mem_data_i,
                         next_pc_i, imm_i, cond_i, halt_i, in_err_i};
        valid_d  = (flush_i || halted_q) ? 1'b0 : stall_i ? valid_q : in_valid_i;
        halted_d = halted_q | (retire & mw_q.halt);
        err_d    = err_q | (retire & (mw_q.in_err | ~legal));
        cnt_d    = cnt_q + CNT_W'(retire);
    end

    // State registers with synchronous reset to an empty, un-halted, error-free pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            mw_q     <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mw_q     <= mw_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed scoreboard bench for the writeback stage
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, reg_wrt, cond, halt, in_err;
    logic [2:0]  write_reg, src;
    logic [15:0] alu, mem, pc, imm;
    logic [15:0] wdata, wdata2;
    logic        wen, wen2, halted, halted2, err, err2;
    logic [2:0]  waddr, waddr2;
    logic [15:0] cnt;
    logic [3:0]  cnt2;

    typedef struct {
        logic        en;
        logic [2:0]  addr;
        logic [15:0] data;
        bit          ca;
        bit          cd;
    } wr_t;

    wr_t sb[$];
    int  checks = 0;
    int  errors = 0;

    writeback_stage dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .stall_i(stall), .flush_i(flush),
        .reg_wrt_i(reg_wrt), .write_reg_i(write_reg), .reg_wrt_data_src_i(src),
        .alu_result_i(alu), .mem_data_i(mem), .next_pc_i(pc), .imm_i(imm), .cond_i(cond),
        .halt_i(halt), .in_err_i(in_err), .reg_wrt_data_o(wdata), .reg_wrt_en_o(wen),
        .reg_wrt_addr_o(waddr), .halted_o(halted), .err_o(err), .retire_cnt_o(cnt)
    );

    writeback_stage #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .stall_i(stall), .flush_i(flush),
        .reg_wrt_i(reg_wrt), .write_reg_i(write_reg), .reg_wrt_data_src_i(src),
        .alu_result_i(alu), .mem_data_i(mem), .next_pc_i(pc), .imm_i(imm), .cond_i(cond),
        .halt_i(halt), .in_err_i(in_err), .reg_wrt_data_o(wdata2), .reg_wrt_en_o(wen2),
        .reg_wrt_addr_o(waddr2), .halted_o(halted2), .err_o(err2), .retire_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic en, input logic [2:0] a, input logic [15:0] d,
                             input bit ca = 1'b1, input bit cd = 1'b1);
        sb.push_back('{en, a, d, ca, cd});
    endtask

    task automatic pop_check(input string tag);
        wr_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=empty_queue expected=entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, ".en"}, 32'(wen), 32'(e.en));
        if (e.ca) chk({tag, ".addr"}, 32'(waddr), 32'(e.addr));
        if (e.cd) chk({tag, ".data"}, 32'(wdata), 32'(e.data));
    endtask

    task automatic status(input string tag, input logic h, input logic e, input logic [15:0] c);
        chk({tag, ".halted"}, 32'(halted), 32'(h));
        chk({tag, ".err"}, 32'(err), 32'(e));
        chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    endtask

    task automatic bubble;
        in_valid = 0; stall = 0; flush = 0; reg_wrt = 0; write_reg = 0; src = 0;
        alu = 0; mem = 0; pc = 0; imm = 0; cond = 0; halt = 0; in_err = 0;
    endtask

    task automatic op(input logic v, input logic rw, input logic [2:0] a, input logic [2:0] s,
                      input logic [15:0] d, input logic h = 1'b0, input logic ie = 1'b0);
        bubble;
        in_valid = v; reg_wrt = rw; write_reg = a; src = s; alu = d;
        mem = 16'hD00D; pc = 16'hC0DE; imm = 16'h1A1A; halt = h; in_err = ie;
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        bubble;
        rst = 1;
        expect_wr(0, 0, 0);
        tick;
        pop_check("reset");
        status("reset", 0, 0, 0);
        chk("reset.cnt_w", 32'(cnt2), 0);
        rst = 0;

        op(1, 1, 3, 0, 16'h1234); expect_wr(1, 3, 16'h1234); tick; pop_check("alu");
        status("alu_pre", 0, 0, 0);
        bubble; expect_wr(0, 0, 0); tick; pop_check("alu_next");
        status("alu_ret", 0, 0, 1);

        op(1, 1, 5, 1, 16'h9999); mem = 16'hBEEF; expect_wr(1, 5, 16'hBEEF); tick;
        pop_check("load0");
        for (int i = 0; i < 3; i++) begin
            stall = 1; in_valid = 0; alu = 16'h0BAD; write_reg = 0; mem = 0;
            expect_wr(1, 5, 16'hBEEF); tick; pop_check("load_held");
            status("load_stall", 0, 0, 1);
        end
        bubble; expect_wr(0, 0, 0); tick; pop_check("load_rel");
        status("load_ret", 0, 0, 2);

        op(1, 1, 7, 2, 16'h2222); pc = 16'h0042; expect_wr(1, 7, 16'h0042); tick;
        pop_check("jal");
        op(1, 1, 2, 4, 16'hFFFF); cond = 1; expect_wr(1, 2, 16'h0001); tick;
        pop_check("set_cond");
        op(1, 1, 4, 3, 16'h3333); imm = 16'h00A5; expect_wr(1, 4, 16'h00A5); tick;
        pop_check("imm");
        op(1, 0, 6, 0, 16'h7E7E); expect_wr(0, 6, 16'h7E7E); tick; pop_check("nowrite");
        status("seq_cnt", 0, 0, 5);

        op(1, 1, 6, 0, 16'h5555); expect_wr(1, 6, 16'h5555); tick; pop_check("pre_flush");
        stall = 1; flush = 1; expect_wr(0, 0, 0, 0, 1); tick; pop_check("stall_flush");
        status("stall_flush", 0, 0, 6);
        bubble; expect_wr(0, 0, 0); tick; pop_check("post_flush");
        status("post_flush", 0, 0, 6);

        op(1, 1, 2, 0, 16'h7777, 1); expect_wr(0, 2, 16'h7777); tick; pop_check("halt_present");
        status("halt_present", 0, 0, 6);
        op(1, 1, 1, 0, 16'h1111); expect_wr(0, 1, 0, 1, 0); tick; pop_check("after_halt");
        status("after_halt", 1, 0, 7);
        for (int i = 0; i < 2; i++) begin
            op(1, 1, 1, 0, 16'h1212); expect_wr(0, 0, 0, 0, 1); tick; pop_check("frozen");
            status("frozen", 1, 0, 7);
        end
        rst = 1; bubble; expect_wr(0, 0, 0); tick; pop_check("rst_halt");
        status("rst_halt", 0, 0, 0);
        rst = 0;

        op(1, 1, 3, 6, 16'hABCD); expect_wr(0, 3, 16'h0000); tick; pop_check("illegal");
        status("illegal_pre", 0, 0, 0);
        bubble; expect_wr(0, 0, 0); tick; pop_check("illegal_next");
        status("illegal_ret", 0, 1, 1);
        op(1, 1, 4, 0, 16'h4444); expect_wr(1, 4, 16'h4444); tick; pop_check("write_after_err");
        bubble; expect_wr(0, 0, 0); tick; pop_check("sticky");
        status("sticky", 0, 1, 2);

        rst = 1; bubble; expect_wr(0, 0, 0); tick; pop_check("rst_err");
        status("rst_err", 0, 0, 0);
        rst = 0;
        op(1, 1, 4, 0, 16'h4444, 0, 1); expect_wr(1, 4, 16'h4444); tick; pop_check("in_err");
        status("in_err_pre", 0, 0, 0);
        bubble; expect_wr(0, 0, 0); tick; pop_check("in_err_next");
        status("in_err_ret", 0, 1, 1);

        op(1, 1, 5, 0, 16'h5A5A); expect_wr(1, 5, 16'h5A5A); tick; pop_check("pre_rst_stall");
        stall = 1; rst = 1; expect_wr(0, 0, 0); tick; pop_check("rst_stall");
        status("rst_stall", 0, 0, 0);
        rst = 0; bubble; expect_wr(0, 0, 0); tick; pop_check("post_rst_stall");
        status("post_rst_stall", 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            op(1, 0, 0, 0, 16'(i)); tick;
        end
        bubble; tick;
        chk("wrap.max", 32'(cnt2), 32'hF);
        chk("wrap.cnt15", 32'(cnt), 15);
        op(1, 0, 0, 0, 16'h0); tick;
        bubble; tick;
        chk("wrap.zero", 32'(cnt2), 0);
        chk("wrap.cnt16", 32'(cnt), 16);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
